trackball_emu: RTL

- Generates the Atari-style trackball inputs (4-bit position counters plus direction flags per axis) that the centipede core reads on its trakball_i port.
- Sources are the digital joystick directions from arcade_inputs and optional signed mouse deltas from user_io.
- Adds joystick acceleration and rate-limited stepping so the game's trackball sampling never misses a count.
- Sits between the input-mapping stage and the core, in the clk_12 domain.

---
 rtl/trackball_emu.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/trackball_emu.sv
// Trackball emulation for the centipede core: joystick with acceleration and
// signed mouse deltas drive rate-limited 4-bit position counters per axis.

module trackball_axis #(
   parameter int STEP_DIV    = 3000,
   parameter int ACCEL_TICKS = 32,
   parameter int ACCEL_MAX   = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_pos,
   input  logic       btn_neg,
   input  logic [1:0] speed,
   input  logic       strobe,
   input  logic [8:0] delta,
   output logic [3:0] cnt,
   output logic       dir
);

   localparam int SW = $clog2(STEP_DIV + 1);
   localparam int HW = $clog2(ACCEL_TICKS + 1);

   typedef enum logic [1:0] {JS_IDLE, JS_POS, JS_NEG} js_t;

   js_t                js_cur, js_q;
   logic [2:0]         level_q, level_d, level_eff;
   logic [HW-1:0]      hold_q, hold_d, hold_eff;
   logic [3:0]         lvl1;
   logic [6:0]         mag;
   logic signed [10:0] pend_q, pend_d;
   logic [SW-1:0]      sp_q, sp_d;
   logic               step, step_neg;
   logic signed [12:0] contrib, mdelta, steptk, sum;

   // Opposing buttons held together cancel to IDLE.
   always_comb begin
      js_cur = JS_IDLE;
      if (btn_pos && !btn_neg)
         js_cur = JS_POS;
      else if (btn_neg && !btn_pos)
         js_cur = JS_NEG;
   end

   // A direction change restarts acceleration in the same cycle it is seen.
   always_comb begin
      level_eff = (js_cur != js_q) ? 3'd0 : level_q;
      hold_eff  = (js_cur != js_q) ? '0 : hold_q;
      level_d   = level_eff;
      hold_d    = hold_eff;
      lvl1      = {1'b0, level_eff} + 4'd1;
      mag       = 7'(lvl1) << speed;
      contrib   = '0;
      if (tick && js_cur != JS_IDLE) begin
         contrib = {6'b0, mag};
         if (js_cur == JS_NEG)
            contrib = -contrib;
         if (hold_eff == HW'(ACCEL_TICKS - 1)) begin
            hold_d = '0;
            if (level_eff != 3'(ACCEL_MAX))
               level_d = level_eff + 3'd1;
         end else begin
            hold_d = hold_eff + 1'b1;
         end
      end
   end

   // Steps are decided from registered pending, so a same-cycle delta composes.
   always_comb begin
      step     = (sp_q == SW'(STEP_DIV - 1)) && (pend_q != 11'sd0);
      step_neg = pend_q[10];
      sp_d     = sp_q;
      if (step)
         sp_d = '0;
      else if (sp_q != SW'(STEP_DIV - 1))
         sp_d = sp_q + 1'b1;
      steptk = step ? (step_neg ? -13'sd1 : 13'sd1) : 13'sd0;
      mdelta = strobe ? {{4{delta[8]}}, delta} : 13'sd0;
      sum    = {{2{pend_q[10]}}, pend_q} + contrib + mdelta - steptk;
      if (sum > 13'sd1023)
         pend_d = 11'sd1023;
      else if (sum < -13'sd1023)
         pend_d = -11'sd1023;
      else
         pend_d = sum[10:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         js_q    <= JS_IDLE;
         level_q <= '0;
         hold_q  <= '0;
         pend_q  <= '0;
         sp_q    <= '0;
         cnt     <= '0;
         dir     <= 1'b0;
      end else begin
         js_q    <= js_cur;
         level_q <= level_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         sp_q    <= sp_d;
         if (step) begin
            cnt <= step_neg ? cnt - 4'd1 : cnt + 4'd1;
            dir <= step_neg;
         end
      end
   end

endmodule

module trackball_emu #(
   parameter int TICK_DIV    = 12000,
   parameter int STEP_DIV    = 3000,
   parameter int ACCEL_TICKS = 32,
   parameter int ACCEL_MAX   = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       joy_up,
   input  logic       joy_down,
   input  logic       joy_left,
   input  logic       joy_right,
   input  logic [1:0] speed,
   input  logic       mouse_strobe,
   input  logic [8:0] mouse_dx,
   input  logic [8:0] mouse_dy,
   output logic       h_dir,
   output logic       v_dir,
   output logic [7:0] trakball_o
);

   localparam int TW = $clog2(TICK_DIV + 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    h_cnt, v_cnt;

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   // Right and down count up; left and up count down.
   trackball_axis #(.STEP_DIV(STEP_DIV), .ACCEL_TICKS(ACCEL_TICKS), .ACCEL_MAX(ACCEL_MAX)) u_h (
      .clk(clk), .reset(reset), .tick(tick), .btn_pos(joy_right), .btn_neg(joy_left),
      .speed(speed), .strobe(mouse_strobe), .delta(mouse_dx), .cnt(h_cnt), .dir(h_dir)
   );

   trackball_axis #(.STEP_DIV(STEP_DIV), .ACCEL_TICKS(ACCEL_TICKS), .ACCEL_MAX(ACCEL_MAX)) u_v (
      .clk(clk), .reset(reset), .tick(tick), .btn_pos(joy_down), .btn_neg(joy_up),
      .speed(speed), .strobe(mouse_strobe), .delta(mouse_dy), .cnt(v_cnt), .dir(v_dir)
   );

   assign trakball_o = {v_cnt, h_cnt};

endmodule
